// File: rtl/edge_detect_bank_if.sv
// Port bundle for edge_detect_bank: raw level inputs, per-channel mode and clear
// controls, and the filtered level / edge / sticky-flag outputs.
interface edge_detect_bank_if #(
    parameter int CH = 8
);
    logic [CH-1:0]   in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   out;
    logic [CH-1:0]   rising;
    logic [CH-1:0]   falling;
    logic [CH-1:0]   evt;
    logic [CH-1:0]   flag;
    logic            any_flag;

    modport master (
        output in, mode, clr,
        input  out, rising, falling, evt, flag, any_flag
    );

    modport slave (
        input  in, mode, clr,
        output out, rising, falling, evt, flag, any_flag
    );
endinterface

// File: rtl/edge_detect_bank.sv
// Multi-channel synchroniser, stability filter and edge/event detector.
// Sticky write-1-to-clear flags are built only when EDGE_BANK_STICKY_EN is defined.
module edge_detect_bank #(
    parameter int CH       = 8,
    parameter int SYNC_STG = 2,
    parameter int FLT_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    edge_detect_bank_if.slave bus
);
    localparam int            CW       = (FLT_CYC > 1) ? $clog2(FLT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FLT_CYC - 1);

    logic [SYNC_STG-1:0][CH-1:0] r_sync;
    logic [CH-1:0][CW-1:0]       r_cnt;
    logic [CH-1:0]               r_out;
    logic [CH-1:0]               r_out_q;

    logic [CH-1:0] w_s;
    logic [CH-1:0] w_rise;
    logic [CH-1:0] w_fall;
    logic [CH-1:0] w_evt;
    logic [CH-1:0] w_mode_rise;
    logic [CH-1:0] w_mode_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, which is what makes the chain shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= bus.in;
            for (int i = 1; i < SYNC_STG; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STG-1];

    // The counter only runs while s disagrees with out, so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_out_q <= '0;
            r_cnt   <= '0;
        end else begin
            r_out_q <= r_out;
            for (int c = 0; c < CH; c++) begin
                if (w_s[c] == r_out[c]) begin
                    r_cnt[c] <= '0;
                end else if (r_cnt[c] == CNT_LAST) begin
                    r_out[c] <= w_s[c];
                    r_cnt[c] <= '0;
                end else begin
                    r_cnt[c] <= r_cnt[c] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_mode_rise = '0;
        w_mode_fall = '0;
        for (int c = 0; c < CH; c++) begin
            w_mode_rise[c] = bus.mode[2*c];
            w_mode_fall[c] = bus.mode[2*c+1];
        end
    end

    assign w_rise = r_out & ~r_out_q;
    assign w_fall = ~r_out & r_out_q;
    assign w_evt  = (w_rise & w_mode_rise) | (w_fall & w_mode_fall);

    assign bus.out     = r_out;
    assign bus.rising  = w_rise;
    assign bus.falling = w_fall;
    assign bus.evt     = w_evt;

`ifdef EDGE_BANK_STICKY_EN
    logic [CH-1:0] r_flag;

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= '0;
        end else begin
            r_flag <= (r_flag & ~bus.clr) | w_evt;
        end
    end

    assign bus.flag     = r_flag;
    assign bus.any_flag = |r_flag;
`else
    logic w_clr_unused;

    assign w_clr_unused = ^bus.clr;
    assign bus.flag     = '0;
    assign bus.any_flag = 1'b0;
`endif

endmodule

// File: tb/tb_edge_detect_bank.sv
// Bench for edge_detect_bank: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a window-based behavioural model.
module tb_edge_detect_bank;
    localparam int CH       = 4;
    localparam int SYNC_STG = 2;
    localparam int FLT_CYC  = 4;
`ifdef EDGE_BANK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_detect_bank_if #(.CH(CH)) bus ();

    edge_detect_bank #(
        .CH       (CH),
        .SYNC_STG (SYNC_STG),
        .FLT_CYC  (FLT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: s is the raw input seen SYNC_STG edges ago; out flips once the last
    // FLT_CYC values of s all disagree with it.
    logic [CH-1:0] m_pipe [SYNC_STG];
    logic [CH-1:0] m_win  [FLT_CYC];
    logic [CH-1:0] m_out, m_out_q, m_flag;

    function automatic logic [CH-1:0] evt_of(input logic [CH-1:0] o, input logic [CH-1:0] oq,
                                             input logic [2*CH-1:0] md);
        logic [CH-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            r[c] = (o[c] & ~oq[c] & md[2*c]) | (~o[c] & oq[c] & md[2*c+1]);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [CH-1:0] s_now;
        logic          differ;
        if (rst) begin
            for (int i = 0; i < SYNC_STG; i++) m_pipe[i] = '0;
            for (int j = 0; j < FLT_CYC; j++) m_win[j] = '0;
            m_out   = '0;
            m_out_q = '0;
            m_flag  = '0;
        end else begin
            s_now = m_pipe[SYNC_STG-1];
            for (int i = SYNC_STG-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = bus.in;
            for (int j = FLT_CYC-1; j > 0; j--) m_win[j] = m_win[j-1];
            m_win[0] = s_now;
            if (STICKY) m_flag = (m_flag & ~bus.clr) | evt_of(m_out, m_out_q, bus.mode);
            m_out_q = m_out;
            for (int c = 0; c < CH; c++) begin
                differ = 1'b1;
                for (int j = 0; j < FLT_CYC; j++) begin
                    if (m_win[j][c] == m_out[c]) differ = 1'b0;
                end
                if (differ) m_out[c] = ~m_out[c];
            end
        end
        #1;
        check("cmp_out",      bus.out,      m_out);
        check("cmp_rising",   bus.rising,   m_out & ~m_out_q);
        check("cmp_falling",  bus.falling,  ~m_out & m_out_q);
        check("cmp_evt",      bus.evt,      evt_of(m_out, m_out_q, bus.mode));
        check("cmp_flag",     bus.flag,     m_flag);
        check("cmp_any_flag", bus.any_flag, |m_flag);
    end

    task automatic toggle_ch2(output int nr, output int nf, output int ne, output int nx);
        nr = 0; nf = 0; ne = 0; nx = 0;
        bus.in[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            nr += int'(bus.rising[2]);
            nf += int'(bus.falling[2]);
            ne += int'(bus.evt[2]);
            nx += int'(bus.evt[2] & ~bus.falling[2]);
            if (k == 9) bus.in[2] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nr, nf, ne, nx;
        bit  found;
        bus.in   = '0;
        bus.mode = '0;
        bus.clr  = '0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out",      bus.out,      0);
        check("rst_flag",     bus.flag,     0);
        check("rst_any_flag", bus.any_flag, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out",  bus.out,    0);
        check("post_rst_rise", bus.rising, 0);

        // Clean edge on channel 0, rising-only mode.
        bus.mode[1:0] = 2'b01;
        bus.in[0]     = 1'b1;
        repeat (5) @(negedge clk);
        check("clean_out_e5", bus.out[0], 1'b0);
        @(negedge clk);
        check("clean_out_e6",  bus.out[0],    1'b1);
        check("clean_rise_e6", bus.rising[0], 1'b1);
        check("clean_evt_e6",  bus.evt[0],    1'b1);
        check("clean_flag_e6", bus.flag[0],   1'b0);
        @(negedge clk);
        check("clean_rise_e7",     bus.rising[0], 1'b0);
        check("clean_flag_e7",     bus.flag[0],   STICKY);
        check("clean_any_flag_e7", bus.any_flag,  STICKY);

        // Glitch rejection on channel 1: 3 cycles rejected, 4 accepted.
        bus.mode[3:2] = 2'b11;
        bus.in[1]     = 1'b1;
        repeat (3) @(negedge clk);
        bus.in[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("glitch_out",  bus.out[1],    1'b0);
            check("glitch_rise", bus.rising[1], 1'b0);
            check("glitch_evt",  bus.evt[1],    1'b0);
        end
        nr = 0; nf = 0;
        bus.in[1] = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            nr += int'(bus.rising[1]);
            nf += int'(bus.falling[1]);
            if (k == 3) bus.in[1] = 1'b0;
        end
        check("pulse4_rise_cnt", nr, 1);
        check("pulse4_fall_cnt", nf, 1);

        // Mode select on channel 2.
        bus.mode[5:4] = 2'b10;
        toggle_ch2(nr, nf, ne, nx);
        check("mode10_rise_cnt",     nr, 1);
        check("mode10_fall_cnt",     nf, 1);
        check("mode10_evt_cnt",      ne, 1);
        check("mode10_evt_not_fall", nx, 0);
        bus.mode[5:4] = 2'b00;
        toggle_ch2(nr, nf, ne, nx);
        check("mode00_rise_cnt", nr, 1);
        check("mode00_evt_cnt",  ne, 0);

        // Clear racing a set on channel 3.
        bus.mode[7:6] = 2'b11;
        bus.in[3]     = 1'b1;
        found         = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.evt[3]) found = 1'b1;
        end
        check("race_evt_seen", found, 1);
        bus.clr[3] = 1'b1;
        @(negedge clk);
        check("race_flag_hold", bus.flag[3], STICKY);
        @(negedge clk);
        check("race_flag_clr", bus.flag[3], 1'b0);
        bus.clr = '1;
        @(negedge clk);
        bus.clr = '0;
        check("race_flag_all_clr", bus.flag,     0);
        check("race_any_clear",    bus.any_flag, 0);

        // Reset while channel 0's filter is part-way through a count.
        bus.in = 4'b0100;
        repeat (12) @(negedge clk);
        check("pre_rst_out",      bus.out,      4'b0100);
        check("pre_rst_any_flag", bus.any_flag, STICKY);
        bus.in[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out",      bus.out,      0);
        check("midrst_rising",   bus.rising,   0);
        check("midrst_falling",  bus.falling,  0);
        check("midrst_evt",      bus.evt,      0);
        check("midrst_flag",     bus.flag,     0);
        check("midrst_any_flag", bus.any_flag, 0);
        repeat (2) @(negedge clk);
        bus.in = 4'b0001;
        rst    = 1'b0;
        nr     = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 4) check("relrst_out_e5",  bus.out[0],    1'b0);
            if (k == 5) check("relrst_rise_e6", bus.rising[0], 1'b1);
            nr += int'(bus.rising[0]);
        end
        check("relrst_rise_cnt", nr, 1);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(5) == 0) bus.in[c] = ~bus.in[c];
                if ($urandom_range(40) == 0) bus.mode[2*c +: 2] = 2'($urandom_range(3));
            end
            bus.clr = ($urandom_range(6) == 0) ? CH'($urandom_range(15)) : '0;
            if (k == 1500) rst = 1'b1;
            if (k == 1503) rst = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
